// File: rtl/rot16_arbiter_2ch.sv
`default_nettype none
// ============================================================================
// rot16_arbiter_2ch : two-channel round-robin arbiter sharing one 16-bit rotator
// Rev 1.0
// ============================================================================
module rot16_arbiter_2ch (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  input  logic [3:0]  req0_amt,
  input  logic        req0_left,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  input  logic [3:0]  req1_amt,
  input  logic        req1_left,
  output logic        req1_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_id,
  input  logic        out_ready
);

  logic        out_valid_q, out_valid_d;
  logic [15:0] out_data_q,  out_data_d;
  logic        out_id_q,    out_id_d;
  logic        prio_q,      prio_d;

  logic        can_load;
  logic        gnt0, gnt1;
  logic        xfer;
  logic [15:0] sel_data;
  logic [3:0]  sel_amt;
  logic        sel_left;
  logic [3:0]  rot_amt;
  logic [15:0] rot_data;

  // Log-shifter right rotate: stage s rotates by 2**s when amt[s] is set.
  function automatic logic [15:0] rotr16(input logic [15:0] din, input logic [3:0] amt);
    logic [15:0] v;
    v = din;
    if (amt[0]) v = {v[0],    v[15:1]};
    if (amt[1]) v = {v[1:0],  v[15:2]};
    if (amt[2]) v = {v[3:0],  v[15:4]};
    if (amt[3]) v = {v[7:0],  v[15:8]};
    return v;
  endfunction

  always_comb begin
    can_load = !out_valid_q || out_ready;
    gnt0     = req0_valid && (!req1_valid || !prio_q);
    gnt1     = req1_valid && (!req0_valid ||  prio_q);
    xfer     = can_load && (gnt0 || gnt1);

    sel_data = gnt1 ? req1_data : req0_data;
    sel_amt  = gnt1 ? req1_amt  : req0_amt;
    sel_left = gnt1 ? req1_left : req0_left;
    // Left by n equals right by (16-n) mod 16, the 4-bit negation.
    rot_amt  = sel_left ? (4'd0 - sel_amt) : sel_amt;
    rot_data = rotr16(sel_data, rot_amt);
  end

  assign req0_ready = can_load && gnt0;
  assign req1_ready = can_load && gnt1;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    prio_d      = prio_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = rot_data;
      out_id_d    = gnt1;
      prio_d      = ~gnt1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
      out_id_q    <= 1'b0;
      prio_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      prio_q      <= prio_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule
`default_nettype wire

// File: tb/tb_rot16_arbiter_2ch.sv
`default_nettype none
// ============================================================================
// tb_rot16_arbiter_2ch : directed + randomized bench against a behavioural model
// Rev 1.0
// ============================================================================
module tb_rot16_arbiter_2ch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req0_left, req0_ready;
  logic [15:0] req0_data;
  logic [3:0]  req0_amt;
  logic        req1_valid, req1_left, req1_ready;
  logic [15:0] req1_data;
  logic [3:0]  req1_amt;
  logic        out_valid, out_id, out_ready;
  logic [15:0] out_data;

  always #5 clk = ~clk;

  rot16_arbiter_2ch dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req0_left  (req0_left),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .req1_left  (req1_left),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_ready  (out_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: the one-entry result register and the tie-break owner
  logic        m_valid, m_id, m_prio;
  logic [15:0] m_data;
  logic        x0, x1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_rot(input logic [15:0] d, input logic [3:0] a, input logic l);
    int unsigned w, sh, r;
    w  = {16'h0, d};
    sh = {28'h0, a};
    if (l) r = (w << sh) | (w >> (16 - sh));
    else   r = (w >> sh) | (w << (16 - sh));
    return r[15:0];
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = 16'h0; m_id = 1'b0; m_prio = 1'b0;
  endtask

  // One clock: compare at the falling edge, then advance the model on the rising edge.
  task automatic cycle();
    logic can, any, win;
    @(negedge clk);
    can = !m_valid || out_ready;
    any = req0_valid || req1_valid;
    win = (req0_valid && req1_valid) ? m_prio : req1_valid;
    x0  = can && any && (win == 1'b0);
    x1  = can && any && (win == 1'b1);
    check("ready0",    req0_ready, x0);
    check("ready1",    req1_ready, x1);
    check("out_valid", out_valid,  m_valid);
    check("out_data",  out_data,   m_data);
    check("out_id",    out_id,     m_id);
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else if (can && any) begin
      m_valid = 1'b1;
      m_id    = win;
      m_prio  = ~win;
      m_data  = win ? ref_rot(req1_data, req1_amt, req1_left)
                    : ref_rot(req0_data, req0_amt, req0_left);
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  logic [15:0] frozen;

  initial begin
    reset_n = 1'b0;
    req0_valid = 0; req0_data = 0; req0_amt = 0; req0_left = 0;
    req1_valid = 0; req1_data = 0; req1_amt = 0; req1_left = 0;
    out_ready = 1'b1;
    model_reset();
    #2;
    check("rst_valid", out_valid, 1'b0);
    check("rst_data",  out_data,  16'h0);
    check("rst_id",    out_id,    1'b0);
    check("rst_rdy0",  req0_ready, 1'b0);
    check("rst_rdy1",  req1_ready, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    cycle();

    // Basic right / left on channel 0
    req0_valid = 1; req0_data = 16'h8001; req0_amt = 4'd1; req0_left = 0;
    cycle();
    check("basic_r", out_data, 16'hC000);
    check("basic_r_id", out_id, 1'b0);
    req0_left = 1;
    cycle();
    check("basic_l", out_data, 16'h0003);
    req0_valid = 0;
    cycle();

    // Amount sweep, both directions, on channel 1
    for (int l = 0; l < 2; l++) begin
      for (int a = 0; a < 16; a++) begin
        req1_valid = 1; req1_data = 16'h1234; req1_amt = a[3:0]; req1_left = l[0];
        cycle();
        if (a == 0) check("amt0", out_data, 16'h1234);
        if (a == 4 && l == 1) check("left4", out_data, 16'h2341);
      end
    end
    req1_valid = 0;
    cycle();

    // Fairness: both continuously valid, no backpressure
    req0_valid = 1; req0_data = 16'hA5A5; req0_amt = 0; req0_left = 0;
    req1_valid = 1; req1_data = 16'h0F0F; req1_amt = 0; req1_left = 0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      check("fair_id", out_id, k[0]);
      check("fair_valid", out_valid, 1'b1);
    end

    // Backpressure for 3 cycles, then release
    out_ready = 0;
    frozen = out_data;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("bp_frozen", out_data, frozen);
    end
    out_ready = 1;
    #1;
    check("bp_release_rdy0", req0_ready, 1'b1);
    cycle();
    check("bp_release_id", out_id, 1'b0);

    // Channel 1 alone, then a tie
    req0_valid = 0;
    cycle();
    check("solo1_id", out_id, 1'b1);
    req0_valid = 1;
    cycle();
    check("tie_after1", out_id, 1'b0);

    // Asynchronous reset with a pending result
    req1_valid = 0; out_ready = 0;
    cycle();
    req0_valid = 0;
    check("pre_rst_valid", out_valid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_clr_valid", out_valid, 1'b0);
    check("async_clr_data",  out_data,  16'h0);
    model_reset();
    cycle();
    reset_n = 1'b1; out_ready = 1;
    req0_valid = 1; req1_valid = 1;
    cycle();
    check("tie_after_rst", out_id, 1'b0);

    // Randomized traffic; requests held until accepted
    for (int k = 0; k < 400; k++) begin
      if (!req0_valid || x0) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_data  = 16'($urandom);
        req0_amt   = 4'($urandom);
        req0_left  = 1'($urandom);
      end
      if (!req1_valid || x1) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_data  = 16'($urandom);
        req1_amt   = 4'($urandom);
        req1_left  = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
